// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet UART streamer.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } ser_state_e;

   localparam logic [7:0] SYNC_DEFAULT    = 8'hA5;
   localparam int unsigned PKT_BYTES_STD   = 3;
   localparam int unsigned PKT_BYTES_WHEEL = 4;

endpackage

// File: rtl/pkt_fifo.sv
// Packet FIFO: one whole mouse packet per slot, power-of-two depth.
module pkt_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   // Full is taken from the registered count, so a same-cycle pop never frees a slot.
   assign full_o    = (count_q == CW'(DEPTH));
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && (count_q != '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/ps2_stream_tx.sv
// Streams buffered PS/2 mouse packets as framed 8N1 UART bytes:
// SYNC, payload bytes, optional XOR checksum of the payload.
module ps2_stream_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PKT_BYTES  = PKT_BYTES_STD,
   parameter int unsigned CHK_EN     = 1,
   parameter logic [7:0]  SYNC       = SYNC_DEFAULT
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              pkt_valid,
   input  logic [8*PKT_BYTES-1:0]            pkt_data,
   output logic                              pkt_ready,
   input  logic                              clr_ovf,
   output logic                              txd,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              ovf
);

   localparam int unsigned PW    = 8 * PKT_BYTES;
   localparam int unsigned NB    = 1 + PKT_BYTES + CHK_EN;
   localparam int unsigned NSLOT = PKT_BYTES + 2;
   localparam int unsigned IW    = $clog2(NSLOT);
   localparam int unsigned TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
   localparam logic [IW-1:0] LAST = IW'(NB - 1);

   ser_state_e               state_q, state_d;
   logic [TW-1:0]            tmr_q, tmr_d;
   logic [2:0]               bit_q, bit_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [NSLOT-1:0][7:0]    frame_q, frame_d;
   logic                     txd_q, txd_d;
   logic                     ovf_q, ovf_d;
   logic                     fifo_pop, fifo_full, tick;
   logic [PW-1:0]            fifo_rd;
   logic [PKT_BYTES-1:0][7:0] pkt_bytes;

   function automatic logic [7:0] xor_bytes(input logic [PW-1:0] d);
      logic [7:0]    x;
      logic [PW-1:0] t;
      x = 8'h00;
      t = d;
      for (int i = 0; i < int'(PKT_BYTES); i++) begin
         x = x ^ t[7:0];
         t = t >> 8;
      end
      return x;
   endfunction

   pkt_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (pkt_valid),
      .wr_data_i (pkt_data),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_rd),
      .full_o    (fifo_full),
      .count_o   (fifo_count)
   );

   assign pkt_ready = !fifo_full;
   assign pkt_bytes = fifo_rd;
   assign tick      = (tmr_q == '0);
   // A drop wins over a coincident clear.
   assign ovf_d     = (pkt_valid && fifo_full) || (ovf_q && !clr_ovf);

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      bit_d    = bit_q;
      idx_d    = idx_q;
      frame_d  = frame_q;
      fifo_pop = 1'b0;
      if (state_q inside {START, DATA, STOP}) tmr_d = tick ? TMAX : tmr_q - TW'(1);
      case (state_q)
         IDLE: if (fifo_count != '0) state_d = LOAD;
         LOAD: begin
            fifo_pop             = 1'b1;
            frame_d              = '0;
            frame_d[0]           = SYNC;
            frame_d[PKT_BYTES:1] = pkt_bytes;
            frame_d[NSLOT-1]     = (CHK_EN != 0) ? xor_bytes(fifo_rd) : 8'h00;
            idx_d                = '0;
            bit_d                = '0;
            tmr_d                = TMAX;
            state_d              = START;
         end
         START: if (tick) state_d = DATA;
         DATA: if (tick) begin
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 3'd1;
         end
         STOP: if (tick) begin
            bit_d = '0;
            if (idx_q == LAST) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = START;
            end
         end
         default: state_d = IDLE;
      endcase
      // Line level follows the next state so the txd register lines up with state_q.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = frame_d[idx_d][bit_d];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      frame_q <= frame_d;
   end

   assign txd  = txd_q;
   assign busy = (state_q != IDLE);
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_ps2_stream_tx.sv
// Directed bench for ps2_stream_tx: byte scoreboard fed at push time, UART monitor pops it.
module tb_ps2_stream_tx;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pkt_valid, clr_ovf;
   logic [23:0] pkt_data;
   logic        pkt_ready, txd, busy, ovf;
   logic [2:0]  fifo_count;

   logic        valid2, clr2;
   logic [31:0] data2;
   logic        ready2, txd2, busy2, ovf2;
   logic [2:0]  count2;

   always #5 clk = ~clk;

   ps2_stream_tx #(
      .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .PKT_BYTES(3), .CHK_EN(1), .SYNC(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
      .pkt_ready(pkt_ready), .clr_ovf(clr_ovf), .txd(txd), .busy(busy),
      .fifo_count(fifo_count), .ovf(ovf)
   );

   ps2_stream_tx #(
      .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .PKT_BYTES(4), .CHK_EN(0), .SYNC(8'hA5)
   ) dut2 (
      .clk(clk), .rst(rst), .pkt_valid(valid2), .pkt_data(data2),
      .pkt_ready(ready2), .clr_ovf(clr2), .txd(txd2), .busy(busy2),
      .fifo_count(count2), .ovf(ovf2)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_frame(input logic [23:0] d);
      exp_q.push_back(8'hA5);
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[7:0] ^ d[15:8] ^ d[23:16]);
   endtask

   // UART receiver on dut.txd, sampling mid-bit on falling clock edges.
   int         rx_cnt = 0;
   bit         rx_on = 1'b0;
   logic [7:0] rx_sh = 8'h00;
   int         rx_total = 0;

   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         rx_on  = 1'b0;
         rx_cnt = 0;
      end else if (!rx_on) begin
         if (txd === 1'b0) begin
            rx_on  = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == 1) begin
            check("rx_start_bit", {31'd0, txd}, 32'd0);
         end else if (rx_cnt < 1 + 9*CLK_DIV && ((rx_cnt - 1) % CLK_DIV) == 0) begin
            rx_sh = {txd, rx_sh[7:1]};
         end else if (rx_cnt == 1 + 9*CLK_DIV) begin
            check("rx_stop_bit", {31'd0, txd}, 32'd1);
            if (exp_q.size() == 0) check("rx_unexpected_byte", {24'd0, rx_sh}, 32'hFFFF_FFFF);
            else                   check("rx_byte", {24'd0, rx_sh}, {24'd0, exp_q.pop_front()});
            rx_total++;
            rx_on = 1'b0;
         end
      end
   end

   task automatic wait_drain(input int limit, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy !== 1'b0 || exp_q.size() != 0) && n < limit);
      check(tag, {31'd0, (busy === 1'b0 && exp_q.size() == 0)}, 32'd1);
   endtask

   task automatic rx2_byte(output logic [7:0] b);
      int n = 0;
      b = 8'h00;
      do begin
         @(negedge clk);
         n++;
      end while (txd2 !== 1'b0 && n < 100);
      check("rx2_start_found", {31'd0, txd2}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CLK_DIV) @(negedge clk);
         b[i] = txd2;
      end
      repeat (CLK_DIV) @(negedge clk);
      check("rx2_stop_bit", {31'd0, txd2}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n, base, t0, t1;
      int         exp_cnt[6];
      int         exp_rdy[6];
      logic [7:0] b;
      logic [7:0] exp2[5];

      exp_cnt = '{1, 2, 2, 3, 4, 4};
      exp_rdy = '{1, 1, 1, 1, 0, 0};
      rst = 1'b0; pkt_valid = 1'b0; pkt_data = '0; clr_ovf = 1'b0;
      valid2 = 1'b0; data2 = '0; clr2 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_count", {29'd0, fifo_count}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_ready", {31'd0, pkt_ready}, 32'd1);
      #2 rst = 1'b1;
      @(negedge clk);

      // Single packet with explicit expected bytes and timing.
      exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h03); exp_q.push_back(8'h00);
      pkt_valid = 1'b1; pkt_data = 24'h030201;
      @(negedge clk);
      pkt_valid = 1'b0;
      check("p1_count_after_push", {29'd0, fifo_count}, 32'd1);
      check("p1_idle_before_load", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("p1_load_busy", {31'd0, busy}, 32'd1);
      check("p1_load_count", {29'd0, fifo_count}, 32'd1);
      @(negedge clk);
      check("p1_count_after_load", {29'd0, fifo_count}, 32'd0);
      n = 2;
      while (busy === 1'b1 && n < 400) begin
         if (n == 2)  check("p1_first_start", {31'd0, txd}, 32'd0);
         if (n == 42) check("p1_byte1_start", {31'd0, txd}, 32'd0);
         if (n == 46) check("p1_byte1_bit0", {31'd0, txd}, 32'd1);
         if (n > 2 && n < 42 && n != 42) begin end
         @(negedge clk);
         n++;
      end
      check("p1_busy_cycles", n - 1, 32'd201);
      check("p1_scoreboard_empty", exp_q.size(), 32'd0);

      // Checksum E7 case.
      exp_q.push_back(8'hA5); exp_q.push_back(8'h10); exp_q.push_back(8'hFF);
      exp_q.push_back(8'h08); exp_q.push_back(8'hE7);
      pkt_valid = 1'b1; pkt_data = 24'h08FF10;
      @(negedge clk);
      pkt_valid = 1'b0;
      wait_drain(400, "p2_frame_done");

      // Six back-to-back pushes into a depth-4 FIFO.
      for (int i = 0; i < 6; i++) begin
         pkt_valid = 1'b1;
         pkt_data  = {8'(8'h30 + i), 8'(8'hC0 ^ i), 8'(8'h11 * (i + 1))};
         if (i < 5) expect_frame(pkt_data);
         @(negedge clk);
         check("burst_count", {29'd0, fifo_count}, exp_cnt[i]);
         check("burst_ready", {31'd0, pkt_ready}, exp_rdy[i]);
      end
      pkt_valid = 1'b0;
      check("burst_ovf_set", {31'd0, ovf}, 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("burst_ovf_cleared", {31'd0, ovf}, 32'd0);

      // Push on the pop edge while full.
      n = 0;
      while (busy !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("gap_idle_seen", {31'd0, busy}, 32'd0);
      check("gap_count_full", {29'd0, fifo_count}, 32'd4);
      @(negedge clk);
      check("gap_load_busy", {31'd0, busy}, 32'd1);
      pkt_valid = 1'b1; pkt_data = 24'hDEAD01;
      @(negedge clk);
      pkt_valid = 1'b0;
      check("pushpop_count", {29'd0, fifo_count}, 32'd3);
      check("pushpop_ovf", {31'd0, ovf}, 32'd1);
      wait_drain(1200, "burst_frames_done");
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;

      // Reset in the middle of a frame with two packets queued.
      for (int i = 0; i < 3; i++) begin
         pkt_valid = 1'b1;
         pkt_data  = {8'(8'h70 + i), 8'(8'h5C ^ i), 8'(8'h21 + i)};
         if (i == 0) expect_frame(pkt_data);
         @(negedge clk);
      end
      pkt_valid = 1'b0;
      base = rx_total;
      n = 0;
      while (rx_total < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("mid_bytes_received", rx_total - base, 32'd2);
      check("mid_count_queued", {29'd0, fifo_count}, 32'd2);
      repeat (8) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_txd", {31'd0, txd}, 32'd1);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_count", {29'd0, fifo_count}, 32'd0);
      check("arst_ready", {31'd0, pkt_ready}, 32'd1);
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b1;
      pkt_valid = 1'b1; pkt_data = 24'h5A3C11;
      expect_frame(pkt_data);
      @(negedge clk);
      pkt_valid = 1'b0;
      check("first_edge_push", {29'd0, fifo_count}, 32'd1);
      wait_drain(400, "post_reset_frame");

      // Wheel packets, no checksum.
      exp2 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
      valid2 = 1'b1; data2 = 32'h44332211;
      @(negedge clk);
      valid2 = 1'b0;
      n = 0;
      while (busy2 !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("w_busy_rise", {31'd0, busy2}, 32'd1);
      t0 = cyc;
      for (int i = 0; i < 5; i++) begin
         rx2_byte(b);
         check("w_byte", {24'd0, b}, {24'd0, exp2[i]});
      end
      n = 0;
      while (busy2 !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      check("w_frame_cycles", t1 - t0, 32'd201);
      for (int i = 0; i < 6; i++) begin
         valid2 = 1'b1;
         data2  = {8'(i), 8'(8'h90 + i), 8'(8'h0F ^ i), 8'(8'h55 + i)};
         clr2   = (i == 5);
         @(negedge clk);
      end
      valid2 = 1'b0; clr2 = 1'b0;
      check("w_count_full", {29'd0, count2}, 32'd4);
      check("w_drop_with_clr", {31'd0, ovf2}, 32'd1);
      clr2 = 1'b1;
      @(negedge clk);
      clr2 = 1'b0;
      check("w_clr_alone", {31'd0, ovf2}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
